pbit_link_sender: RTL and testbench

- Parametrised successor to the single-link p-bit packer.
- Serialises NUM_LINKS independent p-bit slices onto NUM_LINKS FMC/FMC+ lanes, all in one clock domain (the forwarded slow BRAM-read clock).
- Adds a coherent snapshot of every link's p-bits at frame start, a per-link enable mask, continuous and single-shot modes, an optional per-link XOR parity beat, and a frame counter for the tictoc/readout logic.

---
 rtl/pbit_link_sender_pkg.sv | 16 +
 rtl/pbit_lane_serializer.sv | 67 ++++++
 rtl/pbit_link_sender.sv | 107 ++++++++++
 tb/tb_pbit_link_sender.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_link_sender_pkg.sv
// rtl/pbit_link_sender_pkg.sv - shared types and helpers for the multi-link p-bit sender
package pbit_link_sender_pkg;

    localparam int FRAME_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } link_tx_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pbit_lane_serializer.sv
// rtl/pbit_lane_serializer.sv - one lane: shadow slice, beat mux with zero padding, XOR parity
module pbit_lane_serializer
    import pbit_link_sender_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int PBITS_PER_LINK = 64,
    parameter int BEATS          = 4,
    parameter int BEAT_W         = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic                      i_lane_en,
    input  logic [PBITS_PER_LINK-1:0] i_pbits,
    input  link_tx_state_t            i_nxt_state,
    input  logic [BEAT_W-1:0]         i_nxt_beat,
    input  logic                      i_nxt_last,
    output logic [DATA_WIDTH-1:0]     o_tdata,
    output logic                      o_tvalid,
    output logic                      o_tlast
);

    logic [PBITS_PER_LINK-1:0]   r_shadow;
    logic                        r_lane_en;
    logic [PBITS_PER_LINK-1:0]   w_src;
    logic [BEATS*DATA_WIDTH-1:0] w_padded;
    logic [DATA_WIDTH-1:0]       w_parity;
    logic [DATA_WIDTH-1:0]       w_data;
    logic                        w_lane_en;

    // On a load cycle the outgoing beat 0 comes straight from i_pbits so it can be registered at once.
    always_comb begin
        w_src     = i_load ? i_pbits : r_shadow;
        w_lane_en = i_load ? i_lane_en : r_lane_en;
        w_padded  = '0;
        w_padded[PBITS_PER_LINK-1:0] = w_src;
        w_parity  = '0;
        for (int k = 0; k < BEATS; k++) begin
            w_parity = w_parity ^ w_padded[k*DATA_WIDTH +: DATA_WIDTH];
        end
        w_data = '0;
        if (i_nxt_state == SEND) begin
            w_data = w_padded[int'(i_nxt_beat)*DATA_WIDTH +: DATA_WIDTH];
        end else if (i_nxt_state == PARITY) begin
            w_data = w_parity;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_lane_en <= 1'b0;
            o_tdata   <= '0;
            o_tvalid  <= 1'b0;
            o_tlast   <= 1'b0;
        end else begin
            if (i_load) begin
                r_shadow  <= i_pbits;
                r_lane_en <= i_lane_en;
            end
            o_tvalid <= w_lane_en && (i_nxt_state != IDLE);
            o_tdata  <= w_lane_en ? w_data : '0;
            o_tlast  <= w_lane_en && i_nxt_last;
        end
    end

endmodule

// File: rtl/pbit_link_sender.sv
// rtl/pbit_link_sender.sv - serialises NUM_LINKS p-bit slices onto beat-aligned lanes
module pbit_link_sender
    import pbit_link_sender_pkg::*;
#(
    parameter int NUM_LINKS      = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int PBITS_PER_LINK = 64,
    parameter int ADD_PARITY     = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                mode,
    input  logic                                start,
    input  logic [NUM_LINKS-1:0]                link_enable,
    input  logic [NUM_LINKS*PBITS_PER_LINK-1:0] pbits,
    output logic [NUM_LINKS*DATA_WIDTH-1:0]     tx_tdata,
    output logic [NUM_LINKS-1:0]                tx_tvalid,
    output logic [NUM_LINKS-1:0]                tx_tlast,
    output logic                                busy,
    output logic [FRAME_COUNT_WIDTH-1:0]        frame_count,
    output logic                                snapshot_pulse
);

    localparam int                BEATS      = ceil_div(PBITS_PER_LINK, DATA_WIDTH);
    localparam int                BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam bit                HAS_PARITY = (ADD_PARITY != 0);

    link_tx_state_t    r_state;
    logic [BEAT_W-1:0] r_beat;
    link_tx_state_t    w_nxt_state;
    logic [BEAT_W-1:0] w_nxt_beat;
    logic              w_go;
    logic              w_frame_end;
    logic              w_load;
    logic              w_nxt_last;

    // r_state/r_beat describe the beat currently on the lanes; w_nxt_* is the beat registered next.
    always_comb begin
        w_go        = enable && (!mode || start);
        w_frame_end = (r_state == PARITY) ||
                      ((r_state == SEND) && (r_beat == LAST_BEAT) && !HAS_PARITY);
        w_load      = ((r_state == IDLE) && w_go) || (w_frame_end && enable && !mode);
        w_nxt_state = r_state;
        w_nxt_beat  = r_beat;
        if (w_load) begin
            w_nxt_state = SEND;
            w_nxt_beat  = '0;
        end else begin
            case (r_state)
                SEND: begin
                    if (r_beat == LAST_BEAT) begin
                        w_nxt_state = HAS_PARITY ? PARITY : IDLE;
                        w_nxt_beat  = '0;
                    end else begin
                        w_nxt_beat = r_beat + 1'b1;
                    end
                end
                PARITY:  w_nxt_state = IDLE;
                default: w_nxt_state = IDLE;
            endcase
        end
        w_nxt_last = (w_nxt_state == PARITY) ||
                     ((w_nxt_state == SEND) && (w_nxt_beat == LAST_BEAT) && !HAS_PARITY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_beat         <= '0;
            busy           <= 1'b0;
            frame_count    <= '0;
            snapshot_pulse <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_beat         <= w_nxt_beat;
            busy           <= (w_nxt_state != IDLE);
            snapshot_pulse <= w_load;
            if (w_nxt_last) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LINKS; g++) begin : g_lane
        pbit_lane_serializer #(
            .DATA_WIDTH     (DATA_WIDTH),
            .PBITS_PER_LINK (PBITS_PER_LINK),
            .BEATS          (BEATS),
            .BEAT_W         (BEAT_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .i_load      (w_load),
            .i_lane_en   (link_enable[g]),
            .i_pbits     (pbits[g*PBITS_PER_LINK +: PBITS_PER_LINK]),
            .i_nxt_state (w_nxt_state),
            .i_nxt_beat  (w_nxt_beat),
            .i_nxt_last  (w_nxt_last),
            .o_tdata     (tx_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_tvalid    (tx_tvalid[g]),
            .o_tlast     (tx_tlast[g])
        );
    end

endmodule

// File: tb/tb_pbit_link_sender.sv
// tb/tb_pbit_link_sender.sv - scoreboard bench for pbit_link_sender with a frame-level reference model
module tb_pbit_link_sender;

    localparam int NL = 2;
    localparam int DW = 8;
    localparam int PB = 20;
    localparam int AP = 1;
    localparam int BEATS = (PB + DW - 1) / DW;
    localparam int FL = BEATS + AP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, enable, mode, start;
    logic [NL-1:0]    link_enable;
    logic [NL*PB-1:0] pbits;
    logic [NL*DW-1:0] tx_tdata;
    logic [NL-1:0]    tx_tvalid, tx_tlast;
    logic             busy, snapshot_pulse;
    logic [15:0]      frame_count;

    pbit_link_sender #(.NUM_LINKS(NL), .DATA_WIDTH(DW), .PBITS_PER_LINK(PB), .ADD_PARITY(AP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
        .link_enable(link_enable), .pbits(pbits), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
        .tx_tlast(tx_tlast), .busy(busy), .frame_count(frame_count), .snapshot_pulse(snapshot_pulse)
    );

    // Second build: one 8-bit beat per frame, no parity, to reach the frame counter wrap quickly.
    logic       b_reset, b_enable, b_mode, b_start;
    logic [0:0] b_link_en;
    logic [7:0] b_pbits, b_tdata;
    logic [0:0] b_tvalid, b_tlast;
    logic       b_busy, b_snap;
    logic [15:0] b_fc;

    pbit_link_sender #(.NUM_LINKS(1), .DATA_WIDTH(8), .PBITS_PER_LINK(8), .ADD_PARITY(0)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .mode(b_mode), .start(b_start),
        .link_enable(b_link_en), .pbits(b_pbits), .tx_tdata(b_tdata), .tx_tvalid(b_tvalid),
        .tx_tlast(b_tlast), .busy(b_busy), .frame_count(b_fc), .snapshot_pulse(b_snap)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of beats per lane; m_left counts beats still to show.
    logic [8:0]  q[NL][$];
    int          m_left = 0;
    logic [NL-1:0] m_mask = '0;
    logic        exp_busy = 1'b0, exp_pulse = 1'b0;
    logic [NL-1:0] exp_valid = '0;
    logic [15:0] exp_fc = '0;
    logic        mon_on = 1'b0;

    task automatic push_frame();
        for (int i = 0; i < NL; i++) begin
            int v, par, b;
            if (!link_enable[i]) continue;
            v   = int'(pbits[i*PB +: PB]);
            par = 0;
            for (int k = 0; k < BEATS; k++) begin
                b   = (v >> (k*DW)) & ((1 << DW) - 1);
                par = par ^ b;
                q[i].push_back({(AP == 0 && k == BEATS-1) ? 1'b1 : 1'b0, 8'(b)});
            end
            if (AP != 0) q[i].push_back({1'b1, 8'(par)});
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            for (int i = 0; i < NL; i++) q[i].delete();
            exp_busy = 1'b0; exp_pulse = 1'b0; exp_valid = '0; exp_fc = '0;
        end else begin
            if (enable && ((m_left == 0 && (!mode || start)) || (m_left == 1 && !mode))) begin
                push_frame();
                m_mask    = link_enable;
                m_left    = FL;
                exp_pulse = 1'b1;
            end else begin
                if (m_left > 0) m_left--;
                exp_pulse = 1'b0;
            end
            exp_busy  = (m_left > 0);
            exp_valid = exp_busy ? m_mask : '0;
            if (m_left == 1) exp_fc = exp_fc + 16'd1;
        end
    end

    logic [8:0] item;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", busy, exp_busy);
            chk("snapshot_pulse", snapshot_pulse, exp_pulse);
            chk("frame_count", frame_count, exp_fc);
            for (int i = 0; i < NL; i++) begin
                chk("tvalid", tx_tvalid[i], exp_valid[i]);
                if (tx_tvalid[i]) begin
                    if (q[i].size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        item = q[i].pop_front();
                        chk("tdata", tx_tdata[i*DW +: DW], item[7:0]);
                        chk("tlast", tx_tlast[i], item[8]);
                    end
                end else begin
                    chk("idle_tdata", tx_tdata[i*DW +: DW], 0);
                    chk("idle_tlast", tx_tlast[i], 0);
                end
            end
        end
    end

    logic b_done = 1'b0;
    initial begin
        int seen, guard;
        b_reset = 1'b1; b_enable = 1'b0; b_mode = 1'b0; b_start = 1'b0;
        b_link_en = 1'b1; b_pbits = 8'hA5;
        repeat (2) @(negedge clk);
        b_reset = 1'b0; b_enable = 1'b1;
        seen = 0; guard = 0;
        while (seen < 65537 && guard < 70000) begin
            @(negedge clk);
            guard++;
            if (b_tlast[0]) begin
                seen++;
                chk("b_frame_count", b_fc, seen & 16'hFFFF);
                if (seen == 65535) chk("b_fc_ffff", b_fc, 16'hFFFF);
                if (seen == 65536) chk("b_fc_wrap", b_fc, 16'h0000);
                if (seen <= 4 || seen >= 65534) chk("b_tdata", b_tdata, 8'hA5);
            end
        end
        chk("b_frames_seen", seen, 65537);
        b_enable = 1'b0;
        b_done   = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
        link_enable = '0; pbits = '0;
        cyc(2);
        mon_on = 1'b1;
        reset  = 1'b0;
        cyc(1);

        // Single shot, lane 0 only, 20'hABCDE -> DE BC 0A, parity 68
        mode = 1'b1; link_enable = 2'b01; pbits = {20'h12345, 20'hABCDE}; enable = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_busy_low", busy, 0);

        // Continuous with both lanes, pbits changing every cycle mid-frame
        mode = 1'b0; link_enable = 2'b11;
        for (int c = 0; c < 12; c++) begin
            pbits = 40'({$urandom, $urandom});
            cyc(1);
        end
        enable = 1'b0;
        cyc(6);

        // Enable dropped at beat 1 of a frame
        enable = 1'b1; pbits = 40'({$urandom, $urandom});
        cyc(2);
        enable = 1'b0;
        cyc(6);

        // Reset in the middle of a frame
        enable = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; enable = 1'b0;
        cyc(3);
        chk("t4_fc_after_reset", frame_count, 0);

        // Start pulsed again while busy in single-shot mode
        mode = 1'b1; enable = 1'b1; start = 1'b1; pbits = 40'({$urandom, $urandom});
        cyc(1);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        chk("t6_one_frame", frame_count, 1);
        chk("t6_busy_low", busy, 0);

        // Randomised mix, including all-zero masks and occasional resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 14) == 0) mode = ~mode;
            start       = ($urandom_range(0, 3) == 0);
            link_enable = 2'($urandom);
            pbits       = 40'({$urandom, $urandom});
            reset       = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        reset = 1'b0; enable = 1'b0; start = 1'b0;
        cyc(8);
        chk("queues_drained", q[0].size() + q[1].size(), 0);

        w = 0;
        while (!b_done && w < 80000) begin
            @(negedge clk);
            w++;
        end
        if (!b_done) chk("b_timeout", 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
